// File: rtl/tsu_pkg.sv
// Shared TSU types: the per-cycle info stream and the extended timestamp entry
// that the marker capture block stores.
package tsu_pkg;

    localparam int PHASE_B_WIDTH = 32;
    localparam int FCLK_DIV_BITS = 3;
    localparam int TSU_SUB_W     = FCLK_DIV_BITS;
    localparam int EPOCH_W       = 8;
    localparam int TSU_SEQ_W     = 8;

    typedef struct packed {
        logic                     marker_v;
        logic [PHASE_B_WIDTH-1:0] phase_b;
    } info;

    typedef struct packed {
        logic [EPOCH_W-1:0]       epoch;
        logic [PHASE_B_WIDTH-1:0] phase_b;
        logic [FCLK_DIV_BITS-1:0] sub;
    } ts_entry;

    localparam int TS_W = $bits(ts_entry);

endpackage

// File: rtl/tsu_cap_fifo.sv
// Generic show-ahead FIFO: rdata is the head entry straight from storage and
// reads as zero while empty. A push while full is accepted only with a pop.
module tsu_cap_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 43
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset: the occupancy count alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/tsu_marker_capture.sv
// Captures {epoch, phase_b, sub} on each TSU marker into a show-ahead FIFO.
// Optional TSU_CAP_SEQNUM_EN adds a per-entry 8-bit sequence number (out_seq).
module tsu_marker_capture
    import tsu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int EPOCH_W = 8,
    parameter int DROP_W  = 8
) (
    input  logic                                         clk,
    input  logic                                         rst_n,
    input  info                                          in_info,
    input  logic [TSU_SUB_W-1:0]                         in_sub,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [EPOCH_W+PHASE_B_WIDTH+TSU_SUB_W-1:0]   out_ts,
`ifdef TSU_CAP_SEQNUM_EN
    output logic [TSU_SEQ_W-1:0]                         out_seq,
`endif
    output logic                                         ovf,
    input  logic                                         clr_ovf,
    output logic [DROP_W-1:0]                            drop_cnt
);

    localparam int ENT_TS_W = EPOCH_W + PHASE_B_WIDTH + TSU_SUB_W;
`ifdef TSU_CAP_SEQNUM_EN
    localparam int ENT_W = ENT_TS_W + TSU_SEQ_W;
`else
    localparam int ENT_W = ENT_TS_W;
`endif

    info                      r_info;
    logic [TSU_SUB_W-1:0]     r_sub;
    logic [PHASE_B_WIDTH-1:0] prev_phase;
    logic [EPOCH_W-1:0]       epoch;
    logic [EPOCH_W-1:0]       epoch_nxt;
    logic [EPOCH_W-1:0]       r_epoch;
    logic                     push;
    logic                     pop;
    logic                     drop;
    logic                     full;
    logic                     empty;
    logic [ENT_W-1:0]         wdata;
    logic [ENT_W-1:0]         rdata;

    // A backwards step of phase_b means it wrapped; the wrap-cycle marker
    // already carries the incremented epoch.
    assign epoch_nxt = (in_info.phase_b < prev_phase) ? epoch + EPOCH_W'(1) : epoch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_info     <= '0;
            r_sub      <= '0;
            prev_phase <= '0;
            epoch      <= '0;
            r_epoch    <= '0;
        end else begin
            r_info     <= in_info;
            r_sub      <= in_sub;
            prev_phase <= in_info.phase_b;
            epoch      <= epoch_nxt;
            r_epoch    <= epoch_nxt;
        end
    end

    assign push      = r_info.marker_v;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready;
    assign drop      = push && full && !pop;

`ifdef TSU_CAP_SEQNUM_EN
    logic [TSU_SEQ_W-1:0] seq_cnt;

    // Counts every marker, dropped or not, so losses show up as gaps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    seq_cnt <= '0;
        else if (push) seq_cnt <= seq_cnt + TSU_SEQ_W'(1);
    end

    assign wdata   = {seq_cnt, r_epoch, r_info.phase_b, r_sub};
    assign out_seq = rdata[ENT_TS_W +: TSU_SEQ_W];
`else
    assign wdata   = {r_epoch, r_info.phase_b, r_sub};
`endif

    assign out_ts = rdata[ENT_TS_W-1:0];

    tsu_cap_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata (wdata),
        .pop   (pop),
        .rdata (rdata),
        .full  (full),
        .empty (empty)
    );

    // A clear in the same cycle as a drop takes precedence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (clr_ovf) begin
            ovf      <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            ovf <= 1'b1;
            if (drop_cnt != '1) drop_cnt <= drop_cnt + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_tsu_marker_capture.sv
// Directed bench for tsu_marker_capture; expected entries queue in a
// scoreboard that a negedge monitor pops on every accepted handshake.
module tb_tsu_marker_capture;
    import tsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    info         in_info;
    logic [2:0]  in_sub;
    logic        out_valid;
    logic        out_ready;
    logic [42:0] out_ts;
    logic        ovf;
    logic        clr_ovf;
    logic [7:0]  drop_cnt;
`ifdef TSU_CAP_SEQNUM_EN
    logic [7:0]  out_seq;
`endif

    tsu_marker_capture dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_info   (in_info),
        .in_sub    (in_sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ts    (out_ts),
`ifdef TSU_CAP_SEQNUM_EN
        .out_seq   (out_seq),
`endif
        .ovf       (ovf),
        .clr_ovf   (clr_ovf),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [42:0] ts;
        logic [7:0]  seq;
    } exp_t;

    exp_t        sbq[$];
    int          total = 0;
    int          bad   = 0;
    logic [7:0]  seq_m;
    logic [31:0] cur_ph;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit mk, input logic [31:0] ph, input logic [2:0] sb);
        in_info.marker_v = mk;
        in_info.phase_b  = ph;
        in_sub           = sb;
        cur_ph           = ph;
        @(posedge clk);
        #1;
        in_info.marker_v = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, cur_ph, 3'd0);
    endtask

    task automatic mark(input logic [31:0] ph, input logic [2:0] sb,
                        input logic [7:0] ep, input bit store);
        exp_t e;
        if (store) begin
            e.ts  = {ep, ph, sb};
            e.seq = seq_m;
            sbq.push_back(e);
        end
        seq_m++;
        drive(1'b1, ph, sb);
    endtask

    task automatic drain(input int n);
        out_ready = 1'b1;
        idle(n);
        out_ready = 1'b0;
    endtask

    task automatic clear_ovf();
        clr_ovf = 1'b1;
        idle(1);
        clr_ovf = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sbq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pop_unexpected: got ts %0h want no entry", out_ts);
            end else begin
                e = sbq.pop_front();
                chk("pop_ts", {21'd0, out_ts}, {21'd0, e.ts});
`ifdef TSU_CAP_SEQNUM_EN
                chk("pop_seq", {56'd0, out_seq}, {56'd0, e.seq});
`endif
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        in_info   = '0;
        in_sub    = '0;
        out_ready = 1'b0;
        clr_ovf   = 1'b0;
        seq_m     = '0;
        cur_ph    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ovf", {63'd0, ovf}, 64'd0);
        chk("rst_drop", {56'd0, drop_cnt}, 64'd0);
        rst_n = 1'b1;

        // single marker: two edges to valid, then pop
        mark(32'h100, 3'd5, 8'h00, 1'b1);
        chk("lat_e0", {63'd0, out_valid}, 64'd0);
        idle(1);
        chk("lat_e1", {63'd0, out_valid}, 64'd1);
        drain(1);
        chk("pop_clear", {63'd0, out_valid}, 64'd0);

        // phase_b wrap: marker in the wrap cycle carries epoch 1
        drive(1'b0, 32'hFFFF_FFF0, 3'd0);
        drive(1'b0, 32'hFFFF_FFF8, 3'd0);
        mark(32'h0000_0004, 3'd2, 8'h01, 1'b1);
        idle(2);
        drain(3);

        // 255 more wraps bring the epoch back to 0
        for (int i = 0; i < 255; i++) begin
            drive(1'b0, 32'hFFFF_FFF0, 3'd0);
            drive(1'b0, 32'h0000_0010, 3'd0);
        end
        mark(32'h20, 3'd1, 8'h00, 1'b1);
        idle(2);
        drain(3);

        // backpressure: 6 markers into 4 entries
        for (int i = 0; i < 6; i++) mark(32'h1000 + i, 3'(i), 8'h00, i < 4);
        idle(1);
        chk("ovf_set", {63'd0, ovf}, 64'd1);
        chk("drop_two", {56'd0, drop_cnt}, 64'd2);
        drain(6);
        chk("ovf_drained", {63'd0, out_valid}, 64'd0);
        clear_ovf();
        chk("clr_ovf", {63'd0, ovf}, 64'd0);
        chk("clr_drop", {56'd0, drop_cnt}, 64'd0);

        // full with simultaneous push and pop
        for (int i = 0; i < 5; i++) mark(32'h2000 + i, 3'(i), 8'h00, 1'b1);
        out_ready = 1'b1;
        idle(1);
        out_ready = 1'b0;
        chk("pp_no_drop", {56'd0, drop_cnt}, 64'd0);
        chk("pp_no_ovf", {63'd0, ovf}, 64'd0);
        mark(32'h2005, 3'd5, 8'h00, 1'b0);
        idle(1);
        chk("pp_still_full", {56'd0, drop_cnt}, 64'd1);
        clear_ovf();
        drain(6);
        chk("pp_drained", {63'd0, out_valid}, 64'd0);

        // clear coincident with a drop
        for (int i = 0; i < 4; i++) mark(32'h3000 + i, 3'(i), 8'h00, 1'b1);
        mark(32'h3004, 3'd4, 8'h00, 1'b0);
        mark(32'h3005, 3'd5, 8'h00, 1'b0);
        chk("pre_clr_ovf", {63'd0, ovf}, 64'd1);
        chk("pre_clr_drop", {56'd0, drop_cnt}, 64'd1);
        clear_ovf();
        chk("coinc_ovf", {63'd0, ovf}, 64'd0);
        chk("coinc_drop", {56'd0, drop_cnt}, 64'd0);

        // 300 drops saturate at 255
        for (int i = 0; i < 300; i++) mark(32'h4000 + i, 3'(i), 8'h00, 1'b0);
        idle(1);
        chk("sat_drop", {56'd0, drop_cnt}, 64'd255);
        chk("sat_ovf", {63'd0, ovf}, 64'd1);
        clear_ovf();
        drain(6);
        chk("sat_drained", {63'd0, out_valid}, 64'd0);

        // reset mid-stream with 3 queued entries (epoch 1)
        drive(1'b0, 32'hFFFF_FFF0, 3'd0);
        for (int i = 0; i < 3; i++) mark(32'h8 + i, 3'(i), 8'h01, 1'b0);
        idle(1);
        chk("mid_valid", {63'd0, out_valid}, 64'd1);
        rst_n            = 1'b0;
        in_info.marker_v = 1'b0;
        in_info.phase_b  = 32'h30;
        cur_ph           = 32'h30;
        seq_m            = '0;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mark(32'h40, 3'd3, 8'h00, 1'b1);
        idle(2);
        drain(3);
        chk("sb_empty", 64'(sbq.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
